seq_detect_ctrl: RTL and testbench

Test-sequencing controller for the PN-generator / sequence-detector pair. On a start request it holds both sub-blocks in reset for one cycle, then releases them and waits a programmable settle time. It then counts detector hits (z) over a programmed window of bit periods and compares the total against an expected count. It reports the result through a busy/done handshake and sits between the PN_seq + seq_detector datapath and the test/host logic.

---
 rtl/seq_test_pkg.sv | 17 +
 rtl/sat_hit_counter.sv | 53 +++++
 rtl/seq_detect_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_test_pkg.sv
// Shared definitions for the PN-generator / sequence-detector test controller.
package seq_test_pkg;

  localparam int DEF_WIN_W  = 8;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_SETTLE = 2;

  // Controller states; prefixed so they never collide with the SETTLE parameter.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/sat_hit_counter.sv
// Saturating hit counter with synchronous clear and a sticky overflow flag.
// The next-state values are exported so the controller can judge pass/fail
// on the same edge that folds in the final hit.
module sat_hit_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             hit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] countNext_o,
  output logic             overflowNext_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  // A hit arriving while already at the maximum is lost and marks the run as overflowed.
  always_comb begin
    countNext_o    = count_q;
    overflowNext_o = overflow_q;
    if (clear_i) begin
      countNext_o    = '0;
      overflowNext_o = 1'b0;
    end else if (en_i && hit_i) begin
      if (count_q == CNT_MAX) begin
        overflowNext_o = 1'b1;
      end else begin
        countNext_o = count_q + 1'b1;
      end
    end
  end

  // Count and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= countNext_o;
      overflow_q <= overflowNext_o;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Test-sequencing controller: resets the PN generator and detector, lets them
// settle, counts detector hits over a window and compares against an expected total.
module seq_detect_ctrl
  import seq_test_pkg::*;
#(
  parameter int WIN_W  = DEF_WIN_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] expected_hits,
  input  logic             z,
  output logic             pn_rst_n,
  output logic             det_rst_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             overflow,
  output logic             pass
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e           state_q, state_d;
  logic [SET_W-1:0] settleCnt_q, settleCnt_d;
  logic [WIN_W-1:0] winCnt_q, winCnt_d;
  logic [WIN_W-1:0] window_q, window_d;
  logic [CNT_W-1:0] expected_q, expected_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rstN_q, rstN_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] expSel;
  logic [CNT_W-1:0] cntNext;
  logic             ovfNext;
  logic             cntClear;
  logic             cntEn;
  logic             inRun;

  // A run starts from a clean count; hits only count in RUN cycles that are not being aborted.
  assign cntClear = (state_q == ST_PRIME);
  assign inRun    = (state_q == ST_RUN);
  assign cntEn    = inRun && !abort;

  sat_hit_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (cntClear),
    .en_i          (cntEn),
    .hit_i         (z),
    .count_o       (hit_count),
    .overflow_o    (overflow),
    .countNext_o   (cntNext),
    .overflowNext_o(ovfNext)
  );

  // Next state, down-counters, latched settings and the registered output values.
  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    winCnt_d    = winCnt_q;
    window_d    = window_q;
    expected_d  = expected_q;
    expSel      = (state_q == ST_PRIME) ? expected_hits : expected_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        window_d   = window_len;
        expected_d = expected_hits;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (SETTLE > 0) begin
          state_d     = ST_SETTLE;
          settleCnt_d = SET_W'(SETTLE - 1);
        end else if (window_len != '0) begin
          state_d  = ST_RUN;
          winCnt_d = window_len - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (settleCnt_q == '0) begin
          if (window_q != '0) begin
            state_d  = ST_RUN;
            winCnt_d = window_q - 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          settleCnt_d = settleCnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (winCnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          winCnt_d = winCnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    rstN_d = (state_d == ST_SETTLE) || (state_d == ST_RUN) || (state_d == ST_DONE);

    pass_d = pass_q;
    if (state_q == ST_PRIME) pass_d = 1'b0;
    if (abort && ((state_q == ST_PRIME) || (state_q == ST_SETTLE) || (state_q == ST_RUN))) begin
      pass_d = 1'b0;
    end
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      pass_d = (cntNext == expSel) && !ovfNext;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      settleCnt_q <= '0;
      winCnt_q    <= '0;
      window_q    <= '0;
      expected_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rstN_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      winCnt_q    <= winCnt_d;
      window_q    <= window_d;
      expected_q  <= expected_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rstN_q      <= rstN_d;
      pass_q      <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pn_rst_n  = rstN_q;
  assign det_rst_n = rstN_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: table-driven runs plus reset, overflow,
// back-to-back start and closed-loop PN/detector sequences.
module tb_seq_detect_ctrl;

  localparam int SETTLE_CYC = 2;

  typedef struct {
    string       name;
    int          win;
    int          expHits;
    logic [63:0] zMask;
    logic [63:0] startMask;
    int          abortCyc;
    int          lastBusy;
    bit          aborted;
    int          expCount;
    bit          expOvf;
    bit          expPass;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] windowLen;
  logic [7:0] expectedHits;
  logic       zDrive;
  logic       loopMode;
  logic       zMux;

  logic       pnRstN, detRstN, busy, done, overflow, pass;
  logic [7:0] hitCount;
  logic       pnRstN4, detRstN4, busy4, done4, overflow4, pass4;
  logic [3:0] hitCount4;

  logic [6:0] lfsr;
  logic [3:0] detSh;
  logic       pnBit;
  logic       detZ;

  int testsRun;
  int testsFailed;

  vec_t vecs[7];
  vec_t ovfVec;
  vec_t loopVec;

  assign zMux = loopMode ? detZ : zDrive;

  seq_detect_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .window_len   (windowLen),
    .expected_hits(expectedHits),
    .z            (zMux),
    .pn_rst_n     (pnRstN),
    .det_rst_n    (detRstN),
    .busy         (busy),
    .done         (done),
    .hit_count    (hitCount),
    .overflow     (overflow),
    .pass         (pass)
  );

  seq_detect_ctrl #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .window_len   (windowLen),
    .expected_hits(expectedHits[3:0]),
    .z            (zMux),
    .pn_rst_n     (pnRstN4),
    .det_rst_n    (detRstN4),
    .busy         (busy4),
    .done         (done4),
    .hit_count    (hitCount4),
    .overflow     (overflow4),
    .pass         (pass4)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Small PN generator model restarted by the controller's reset output.
  always @(posedge clk or negedge pnRstN) begin
    if (!pnRstN) lfsr <= 7'h01;
    else         lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end
  assign pnBit = lfsr[6];

  // Detector model flagging the overlapping pattern 1011.
  always @(posedge clk or negedge detRstN) begin
    if (!detRstN) detSh <= 4'b0;
    else          detSh <= {detSh[2:0], pnBit};
  end
  assign detZ = (detSh == 4'b1011);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Start a run at edge 0 and walk cycles 1..lastBusy+2, checking the handshake each cycle.
  task automatic applyStimulus(input vec_t v, output int seqErrs, output int sbHits);
    seqErrs = 0;
    sbHits  = 0;
    @(negedge clk);
    windowLen    = v.win[7:0];
    expectedHits = v.expHits[7:0];
    abort        = 1'b0;
    zDrive       = 1'b0;
    start        = 1'b1;
    for (int c = 1; c <= v.lastBusy + 2; c++) begin
      logic expBusy, expRst, expDone;
      @(negedge clk);
      expBusy = (c <= v.lastBusy);
      expRst  = (c >= 2) && (c <= v.lastBusy);
      expDone = (c == v.lastBusy) && !v.aborted;
      if (busy !== expBusy || pnRstN !== expRst || detRstN !== expRst || done !== expDone) begin
        seqErrs++;
      end
      if (loopMode && c >= SETTLE_CYC + 2 && c <= SETTLE_CYC + 1 + v.win && detZ) sbHits++;
      start  = v.startMask[c];
      abort  = (c == v.abortCyc);
      zDrive = v.zMask[c];
    end
    start  = 1'b0;
    abort  = 1'b0;
    zDrive = 1'b0;
  endtask

  initial begin
    int errs, sb, sbFirst;
    logic [15:0] busyBits, doneBits;

    testsRun     = 0;
    testsFailed  = 0;
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    zDrive       = 1'b0;
    loopMode     = 1'b0;
    windowLen    = '0;
    expectedHits = '0;

    vecs[0] = '{name:"basic",     win:10, expHits:2, zMask:64'h44C,  startMask:64'h0,   abortCyc:0, lastBusy:14, aborted:0, expCount:2, expOvf:0, expPass:1};
    vecs[1] = '{name:"win0exp0",  win:0,  expHits:0, zMask:64'hC,    startMask:64'h0,   abortCyc:0, lastBusy:4,  aborted:0, expCount:0, expOvf:0, expPass:1};
    vecs[2] = '{name:"win0exp1",  win:0,  expHits:1, zMask:64'h0,    startMask:64'h0,   abortCyc:0, lastBusy:4,  aborted:0, expCount:0, expOvf:0, expPass:0};
    vecs[3] = '{name:"startBusy", win:10, expHits:2, zMask:64'h2010, startMask:64'h108, abortCyc:0, lastBusy:14, aborted:0, expCount:2, expOvf:0, expPass:1};
    vecs[4] = '{name:"abortRun",  win:10, expHits:1, zMask:64'h20,   startMask:64'h0,   abortCyc:7, lastBusy:7,  aborted:1, expCount:1, expOvf:0, expPass:0};
    vecs[5] = '{name:"edgesZ",    win:5,  expHits:3, zMask:64'h338,  startMask:64'h0,   abortCyc:0, lastBusy:9,  aborted:0, expCount:3, expOvf:0, expPass:1};
    vecs[6] = '{name:"win1",      win:1,  expHits:1, zMask:64'h10,   startMask:64'h0,   abortCyc:0, lastBusy:5,  aborted:0, expCount:1, expOvf:0, expPass:1};
    ovfVec  = '{name:"ovf",       win:20, expHits:15, zMask:64'hFFFFF0, startMask:64'h0, abortCyc:0, lastBusy:24, aborted:0, expCount:20, expOvf:0, expPass:0};
    loopVec = '{name:"loop",      win:40, expHits:0, zMask:64'h0,    startMask:64'h0,   abortCyc:0, lastBusy:44, aborted:0, expCount:0, expOvf:0, expPass:0};

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pn", pnRstN, 0);
    checkOutput("rst_det", detRstN, 0);
    checkOutput("rst_hit", hitCount, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_pass", pass, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], errs, sb);
      checkOutput({vecs[i].name, "_seq"}, errs, 0);
      checkOutput({vecs[i].name, "_hit"}, hitCount, vecs[i].expCount);
      checkOutput({vecs[i].name, "_ovf"}, overflow, vecs[i].expOvf);
      checkOutput({vecs[i].name, "_pass"}, pass, vecs[i].expPass);
    end

    applyStimulus(ovfVec, errs, sb);
    checkOutput("ovf_seq", errs, 0);
    checkOutput("ovf_hit8", hitCount, 20);
    checkOutput("ovf_ovf8", overflow, 0);
    checkOutput("ovf_pass8", pass, 0);
    checkOutput("ovf_hit4", hitCount4, 15);
    checkOutput("ovf_ovf4", overflow4, 1);
    checkOutput("ovf_pass4", pass4, 0);

    @(negedge clk);
    windowLen    = 8'd0;
    expectedHits = 8'd0;
    start        = 1'b1;
    busyBits     = '0;
    doneBits     = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      busyBits[c] = busy;
      doneBits[c] = done;
      if (c == 6) start = 1'b0;
    end
    checkOutput("held_busy", busyBits, 16'h03DE);
    checkOutput("held_done", doneBits, 16'h0210);
    checkOutput("held_pass", pass, 1);

    loopMode = 1'b1;
    applyStimulus(loopVec, errs, sbFirst);
    checkOutput("loop1_seq", errs, 0);
    checkOutput("loop1_hit", hitCount, sbFirst);
    applyStimulus(loopVec, errs, sb);
    checkOutput("loop2_seq", errs, 0);
    checkOutput("loop2_hit", hitCount, sb);
    checkOutput("loop2_vs_run1", hitCount, sbFirst);
    loopMode = 1'b0;

    @(negedge clk);
    windowLen    = 8'd10;
    expectedHits = 8'd0;
    start        = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start  = 1'b0;
      zDrive = (c == 4) || (c == 5);
    end
    checkOutput("mid_hit_pre", hitCount, 2);
    checkOutput("mid_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_busy", busy, 0);
    checkOutput("async_done", done, 0);
    checkOutput("async_pn", pnRstN, 0);
    checkOutput("async_det", detRstN, 0);
    checkOutput("async_hit", hitCount, 0);
    checkOutput("async_ovf", overflow, 0);
    checkOutput("async_pass", pass, 0);
    @(negedge clk);
    reset  = 1'b0;
    zDrive = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
